// File: rtl/hog_pio_pkg.sv
// Shared types and constants for the HOG result-word PIO transmit path.
// A PIO word is {req, last, data[29:0]}.
package hog_pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int REQ_BIT  = 31;
    localparam int LAST_BIT = 30;
    localparam int DATA_W   = 30;
    localparam int WORD_W   = DATA_W + 1;

    function automatic logic [31:0] make_word(input logic req, input logic [WORD_W-1:0] word);
        return {req, word};
    endfunction

endpackage

// File: rtl/hog_sync_fifo.sv
// Single-clock FIFO with full/empty/level status.
// Reset flushes the buffer by clearing the pointers and the occupancy count.
module hog_sync_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == {(AW+1){1'b0}});
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage write; entries need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/hog_pio_tx_ctrl.sv
// Moves buffered HOG result words to the HPS over a 32-bit PIO using a
// four-phase req/ack handshake, with per-phase timeout and status counters.
module hog_pio_tx_ctrl
    import hog_pio_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [31:0]                   pio_out,
    input  logic                          pio_ack,
    input  logic                          clear_err,
    output logic                          timeout_err,
    output logic                          frame_done,
    output logic [15:0]                   words_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_r;
    state_t              state_s;
    logic                ack_q_r;
    logic [CNT_W-1:0]    tmo_cnt_r;
    logic [31:0]         pio_out_r;
    logic                err_r;
    logic                frame_done_r;
    logic [15:0]         words_sent_r;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [WORD_W-1:0]   fifo_rdata_s;
    logic                push_s;
    logic                pop_s;
    logic                req_drop_s;
    logic                done_s;
    logic                tmo_s;
    logic                cnt_clr_s;
    logic                tmo_hit_s;

    assign s_ready     = ~fifo_full_s;
    assign push_s      = s_valid & ~fifo_full_s;
    assign pio_out     = pio_out_r;
    assign timeout_err = err_r;
    assign frame_done  = frame_done_r;
    assign words_sent  = words_sent_r;
    assign tmo_hit_s   = (tmo_cnt_r == TO_LAST);

    hog_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata ({s_last, s_data}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Handshake sequencing; an acknowledge edge takes priority over a timeout in the same cycle.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        req_drop_s = 1'b0;
        done_s     = 1'b0;
        tmo_s      = 1'b0;
        cnt_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    cnt_clr_s = 1'b1;
                    state_s   = PRESENT;
                end else begin
                    state_s   = IDLE;
                end
            end
            PRESENT: begin
                if (ack_q_r) begin
                    req_drop_s = 1'b1;
                    cnt_clr_s  = 1'b1;
                    state_s    = RELEASE;
                end else if (tmo_hit_s) begin
                    tmo_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = PRESENT;
                end
            end
            RELEASE: begin
                if (!ack_q_r) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (tmo_hit_s) begin
                    tmo_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and single-stage ack capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            ack_q_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ack_q_r <= pio_ack;
        end
    end

    // Phase timer: restarts on entry to each handshake phase, idles at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s || (state_s == IDLE)) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end

    // PIO word: payload bits change only on a load, so data is stable while req is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pio_out_r <= 32'd0;
        end else if (pop_s) begin
            pio_out_r <= make_word(1'b1, fifo_rdata_s);
        end else if (req_drop_s || tmo_s) begin
            pio_out_r[REQ_BIT] <= 1'b0;
        end else begin
            pio_out_r <= pio_out_r;
        end
    end

    // Status: sticky timeout (set beats clear), frame pulse and completed-word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r        <= 1'b0;
            frame_done_r <= 1'b0;
            words_sent_r <= 16'd0;
        end else begin
            if (tmo_s) begin
                err_r <= 1'b1;
            end else if (clear_err) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            frame_done_r <= done_s & pio_out_r[LAST_BIT];
            if (done_s) begin
                words_sent_r <= words_sent_r + 16'd1;
            end else begin
                words_sent_r <= words_sent_r;
            end
        end
    end

endmodule

// File: tb/tb_hog_pio_tx_ctrl.sv
// Bench for hog_pio_tx_ctrl: directed handshake scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the transmit path.
module tb_hog_pio_tx_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] s_data;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] pio_out;
    logic        pio_ack;
    logic        clear_err;
    logic        timeout_err;
    logic        frame_done;
    logic [15:0] words_sent;
    logic [3:0]  fifo_level;

    logic        ack_drv;
    int          hps_mode;   // 0 hold low, 1 random delays, 2 manual, 3 follow req
    int          n_checks;
    int          n_errors;
    bit          cmp_en;
    bit          preload;
    bit          rec_en;
    logic        prev_req;
    logic [29:0] rec_q[$];

    // Model of the transmit path: queue of pending words plus the word in flight.
    logic [30:0] mq[$];
    bit          m_busy;
    bit          m_wait_hi;
    int          m_cnt;
    logic [31:0] m_pio;
    bit          m_err;
    bit          m_fd;
    logic [15:0] m_ws;
    bit          m_ackq;

    always #5 clk = ~clk;
    assign pio_ack = ack_drv;

    hog_pio_tx_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pio_out     (pio_out),
        .pio_ack     (pio_ack),
        .clear_err   (clear_err),
        .timeout_err (timeout_err),
        .frame_done  (frame_done),
        .words_sent  (words_sent),
        .fifo_level  (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          full_b;
        bit          to;
        logic [30:0] w;
        full_b = (mq.size() == DEPTH);
        to     = 1'b0;
        if (reset) begin
            mq.delete();
            m_pio = 32'd0; m_busy = 1'b0; m_wait_hi = 1'b0; m_cnt = 0;
            m_err = 1'b0; m_fd = 1'b0; m_ws = 16'd0; m_ackq = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (!m_busy) begin
                if (mq.size() > 0) begin
                    w = mq.pop_front();
                    m_pio = {1'b1, w};
                    m_busy = 1'b1; m_wait_hi = 1'b1; m_cnt = 0;
                end
            end else if (m_wait_hi) begin
                if (m_ackq) begin
                    m_pio[31] = 1'b0; m_wait_hi = 1'b0; m_cnt = 0;
                end else if (m_cnt == TO - 1) begin
                    m_pio[31] = 1'b0; m_busy = 1'b0; to = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else begin
                if (!m_ackq) begin
                    m_ws++; m_fd = m_pio[30]; m_busy = 1'b0;
                end else if (m_cnt == TO - 1) begin
                    m_busy = 1'b0; to = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (s_valid && !full_b) mq.push_back({s_last, s_data});
            if (to) m_err = 1'b1;
            else if (clear_err) m_err = 1'b0;
            m_ackq = pio_ack;
            if (preload) m_ws = 16'hFFFF;
        end
    endtask

    // One clock: model update at the edge, comparison and HPS response half a cycle later.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (cmp_en) begin
            chk("pio_out", pio_out, m_pio);
            chk("s_ready", s_ready, (mq.size() != DEPTH));
            chk("fifo_level", fifo_level, mq.size());
            chk("timeout_err", timeout_err, m_err);
            chk("frame_done", frame_done, m_fd);
            chk("words_sent", words_sent, m_ws);
        end
        if (rec_en && pio_out[31] && !prev_req) rec_q.push_back(pio_out[29:0]);
        prev_req = pio_out[31];
        case (hps_mode)
            0: ack_drv = 1'b0;
            1: begin
                if (pio_out[31] && !ack_drv) ack_drv = ($urandom_range(0, 3) == 0);
                else if (!pio_out[31] && ack_drv) ack_drv = ($urandom_range(0, 3) != 0);
                else ack_drv = ack_drv;
            end
            2: ack_drv = ack_drv;
            default: ack_drv = pio_out[31];
        endcase
    endtask

    task automatic push_word(input logic [29:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int fd;
        n_checks = 0; n_errors = 0; cmp_en = 1'b1; preload = 1'b0; rec_en = 1'b0;
        prev_req = 1'b0; hps_mode = 0; ack_drv = 1'b0;
        reset = 1'b1; s_valid = 1'b0; s_data = 30'd0; s_last = 1'b0; clear_err = 1'b0;
        repeat (3) tick();
        chk("rst_pio_out", pio_out, 32'd0);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_words", words_sent, 16'd0);
        chk("rst_err", timeout_err, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        reset = 1'b0;
        tick();

        // Single word with a manual HPS.
        hps_mode = 2;
        push_word(30'h0ABCDEF, 1'b1);
        tick();
        chk("single_pio", pio_out, 32'hC0ABCDEF);
        repeat (4) tick();
        ack_drv = 1'b1;
        cnt = 0;
        while (pio_out[31] && cnt < 10) begin tick(); cnt++; end
        chk("single_req_drop", pio_out[31], 1'b0);
        ack_drv = 1'b0;
        fd = 0;
        repeat (6) begin tick(); fd += int'(frame_done); end
        chk("single_words", words_sent, 16'd1);
        chk("single_fd_pulses", fd, 1);

        // Backpressure: nine words with no ack.
        hps_mode = 0;
        for (int i = 1; i <= 9; i++) push_word(30'(i), 1'b0);
        chk("bp_s_ready", s_ready, 1'b0);
        chk("bp_level", fifo_level, 4'd8);
        chk("bp_pio", pio_out, 32'h80000001);
        s_valid = 1'b1; s_data = 30'd10; s_last = 1'b0;
        repeat (2) tick();
        s_valid = 1'b0;
        chk("bp_level_held", fifo_level, 4'd8);
        rec_en = 1'b1; hps_mode = 3;
        repeat (120) tick();
        rec_en = 1'b0;
        chk("bp_order_count", rec_q.size(), 8);
        for (int i = 0; i < rec_q.size(); i++) chk("bp_order", rec_q[i], 30'(i + 2));
        chk("bp_words", words_sent, 16'd10);

        // Timeout in PRESENT.
        hps_mode = 0;
        push_word(30'h123, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (pio_out[31]) cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, 16);
        chk("to_err", timeout_err, 1'b1);
        chk("to_words", words_sent, 16'd10);

        // Recovery.
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("rec_err_clear", timeout_err, 1'b0);
        hps_mode = 3;
        push_word(30'h2A, 1'b0);
        repeat (20) tick();
        chk("rec_words", words_sent, 16'd11);

        // Clear and timeout in the same cycle.
        hps_mode = 0;
        push_word(30'h55, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (pio_out[31]) cnt++;
            clear_err = pio_out[31] && (cnt == 16);
            tick();
        end
        clear_err = 1'b0;
        chk("prio_err", timeout_err, 1'b1);

        // Counter wrap from a preloaded 0xFFFF.
        cmp_en = 1'b0;
        force dut.words_sent_r = 16'hFFFF;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        release dut.words_sent_r;
        tick();
        cmp_en = 1'b1;
        chk("wrap_pre", words_sent, 16'hFFFF);
        hps_mode = 3;
        push_word(30'h3FFFFFFF, 1'b1);
        repeat (20) tick();
        chk("wrap_words", words_sent, 16'd0);

        // Reset mid-handshake.
        hps_mode = 0;
        for (int i = 0; i < 3; i++) push_word(30'(100 + i), 1'b0);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_pio", pio_out, 32'd0);
        chk("rst_mid_level", fifo_level, 4'd0);
        tick();

        // Randomized traffic.
        hps_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            s_valid   = ($urandom_range(0, 1) == 1);
            s_data    = 30'($urandom());
            s_last    = ($urandom_range(0, 3) == 0);
            clear_err = ($urandom_range(0, 63) == 0);
            tick();
        end
        s_valid = 1'b0; clear_err = 1'b0; hps_mode = 3;
        repeat (100) tick();
        chk("drain_level", fifo_level, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
